// File: rtl/vending_pkg.sv
// Coin encodings, coin values and FSM states shared by the change dispenser,
// its inventory and anything that decodes state_out.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_5    = 2'b10,
    COIN_10   = 2'b11
  } coin_e;

  localparam logic [4:0] VAL_1  = 5'd1;
  localparam logic [4:0] VAL_5  = 5'd5;
  localparam logic [4:0] VAL_10 = 5'd10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  function automatic logic [4:0] coin_value(input coin_e c);
    logic [4:0] v;
    v = '0;
    case (c)
      COIN_1:  v = VAL_1;
      COIN_5:  v = VAL_5;
      COIN_10: v = VAL_10;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change-request and coin-eject handshakes between the vending controller,
// the dispenser and the coin hopper.
interface change_dispenser_if;

  logic       change_valid;
  logic [4:0] change_amount;
  logic       change_ready;
  logic       coin_out_valid;
  logic [1:0] coin_out;
  logic       coin_ack;

  modport master (
    output change_valid, change_amount, coin_ack,
    input  change_ready, coin_out_valid, coin_out
  );

  modport slave (
    input  change_valid, change_amount, coin_ack,
    output change_ready, coin_out_valid, coin_out
  );

endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// Three saturating per-denomination coin counters with refill and single-coin
// decrement; index i holds the denomination whose coin code is i+1.
module coin_inventory
  import vending_pkg::*;
#(
  parameter int unsigned INV_WIDTH = 6,
  parameter int unsigned INV_INIT  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 refill_en_i,
  input  logic [1:0]           refill_type_i,
  input  logic [INV_WIDTH-1:0] refill_count_i,
  input  logic                 dec_en_i,
  input  coin_e                dec_type_i,
  output logic [INV_WIDTH-1:0] inv_1_o,
  output logic [INV_WIDTH-1:0] inv_5_o,
  output logic [INV_WIDTH-1:0] inv_10_o,
  output logic                 zero_1_o,
  output logic                 zero_5_o,
  output logic                 zero_10_o
);

  localparam logic [INV_WIDTH-1:0] INV_MAX = '1;
  localparam logic [INV_WIDTH-1:0] INIT_V  = INV_WIDTH'(INV_INIT);

  logic [INV_WIDTH-1:0] inv_q [3];
  logic [INV_WIDTH-1:0] inv_d [3];
  logic [INV_WIDTH:0]   sum;

  // Refill and decrement fold into one sum so a same-cycle pair nets out
  // before saturation; the extra bit holds the pre-saturation overflow.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      sum = {1'b0, inv_q[i]};
      if (refill_en_i && (refill_type_i == 2'(i + 1)))
        sum = sum + {1'b0, refill_count_i};
      if (dec_en_i && (dec_type_i == coin_e'(2'(i + 1))) && (inv_q[i] != '0))
        sum = sum - (INV_WIDTH + 1)'(1);
      inv_d[i] = (sum > {1'b0, INV_MAX}) ? INV_MAX : sum[INV_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) inv_q[i] <= INIT_V;
    end else begin
      for (int unsigned i = 0; i < 3; i++) inv_q[i] <= inv_d[i];
    end
  end

  assign inv_1_o   = inv_q[0];
  assign inv_5_o   = inv_q[1];
  assign inv_10_o  = inv_q[2];
  assign zero_1_o  = (inv_q[0] == '0);
  assign zero_5_o  = (inv_q[1] == '0);
  assign zero_10_o = (inv_q[2] == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy 10/5/1 change dispenser: takes one change amount per transaction and
// issues coins one at a time over a valid/ack handshake to the hopper.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned INV_WIDTH   = 6,
  parameter int unsigned INV_INIT    = 20,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  change_dispenser_if.slave    cif,
  input  logic                 refill_en,
  input  logic [1:0]           refill_type,
  input  logic [INV_WIDTH-1:0] refill_count,
  input  logic                 clear_fault,
  output logic                 done,
  output logic [4:0]           shortfall,
  output logic                 fault,
  output logic [INV_WIDTH-1:0] inv_1,
  output logic [INV_WIDTH-1:0] inv_5,
  output logic [INV_WIDTH-1:0] inv_10,
  output logic [2:0]           state_out
);

  localparam int unsigned     TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [4:0]       remaining_q, remaining_d;
  coin_e            coin_q, coin_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [4:0]       shortfall_q, shortfall_d;
  logic             dec_en;
  logic             zero_1, zero_5, zero_10;

  coin_inventory #(
    .INV_WIDTH (INV_WIDTH),
    .INV_INIT  (INV_INIT)
  ) u_inventory (
    .clk            (clk),
    .rst            (reset),
    .refill_en_i    (refill_en),
    .refill_type_i  (refill_type),
    .refill_count_i (refill_count),
    .dec_en_i       (dec_en),
    .dec_type_i     (coin_q),
    .inv_1_o        (inv_1),
    .inv_5_o        (inv_5),
    .inv_10_o       (inv_10),
    .zero_1_o       (zero_1),
    .zero_5_o       (zero_5),
    .zero_10_o      (zero_10)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      coin_q      <= COIN_NONE;
      tmo_q       <= '0;
      shortfall_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      tmo_q       <= tmo_d;
      shortfall_q <= shortfall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    tmo_d       = tmo_q;
    shortfall_d = shortfall_q;
    dec_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cif.change_valid) begin
          remaining_d = cif.change_amount;
          shortfall_d = '0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        tmo_d = '0;
        if ((remaining_q >= VAL_10) && !zero_10) begin
          coin_d  = COIN_10;
          state_d = ST_DISPENSE;
        end else if ((remaining_q >= VAL_5) && !zero_5) begin
          coin_d  = COIN_5;
          state_d = ST_DISPENSE;
        end else if ((remaining_q >= VAL_1) && !zero_1) begin
          coin_d  = COIN_1;
          state_d = ST_DISPENSE;
        end else begin
          coin_d      = COIN_NONE;
          shortfall_d = remaining_q;
          remaining_d = '0;
          state_d     = ST_DONE;
        end
      end
      ST_DISPENSE: begin
        if (cif.coin_ack) begin
          remaining_d = remaining_q - coin_value(coin_q);
          dec_en      = 1'b1;
          tmo_d       = '0;
          state_d     = ST_SELECT;
        end else if (tmo_q == TMO_LAST) begin
          // Hopper never answered: the rest of this transaction is abandoned.
          remaining_d = '0;
          coin_d      = COIN_NONE;
          tmo_d       = '0;
          state_d     = ST_FAULT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: if (clear_fault) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign cif.change_ready   = (state_q == ST_IDLE);
  assign cif.coin_out_valid = (state_q == ST_DISPENSE);
  assign cif.coin_out       = (state_q == ST_DISPENSE) ? coin_q : COIN_NONE;
  assign done               = (state_q == ST_DONE);
  assign fault              = (state_q == ST_FAULT);
  assign shortfall          = shortfall_q;
  assign state_out          = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed scoreboard bench for change_dispenser: stimulus queues expected coins
// and done/shortfall events; a negedge monitor pops and compares them.
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       refill_en;
  logic [1:0] refill_type;
  logic [5:0] refill_count;
  logic       clear_fault;
  logic       done;
  logic [4:0] shortfall;
  logic       fault;
  logic [5:0] inv_1, inv_5, inv_10;
  logic [2:0] state_out;

  change_dispenser_if dif ();

  change_dispenser #(
    .INV_WIDTH   (6),
    .INV_INIT    (20),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cif          (dif),
    .refill_en    (refill_en),
    .refill_type  (refill_type),
    .refill_count (refill_count),
    .clear_fault  (clear_fault),
    .done         (done),
    .shortfall    (shortfall),
    .fault        (fault),
    .inv_1        (inv_1),
    .inv_5        (inv_5),
    .inv_10       (inv_10),
    .state_out    (state_out)
  );

  typedef struct {
    bit is_done;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;
  bit   ack_en   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_coin(input int c);
    exp_t e;
    e.is_done = 0;
    e.val     = c;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int s);
    exp_t e;
    e.is_done = 1;
    e.val     = s;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int amt);
    int n;
    n = 0;
    while (!dif.change_ready && n < 50) begin
      tick();
      n++;
    end
    if (!dif.change_ready) chk("ready_wait_timeout", 0, 1);
    dif.change_valid  = 1'b1;
    dif.change_amount = 5'(amt);
    tick();
    dif.change_valid  = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int start;
    int n;
    start = done_cnt;
    n     = 0;
    while (done_cnt == start && n < 200) begin
      tick();
      n++;
    end
    if (done_cnt == start) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!dif.coin_out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({nm, "_valid_seen"}, int'(dif.coin_out_valid), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic check_inv(input string nm, input int e1, input int e5, input int e10);
    chk({nm, "_inv_1"},  int'(inv_1),  e1);
    chk({nm, "_inv_5"},  int'(inv_5),  e5);
    chk({nm, "_inv_10"}, int'(inv_10), e10);
  endtask

  // Hopper model: acks one cycle after it sees an offered coin.
  initial begin
    dif.coin_ack = 1'b0;
    forever begin
      tick();
      if (ack_en) dif.coin_ack = dif.coin_out_valid && !dif.coin_ack;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dif.coin_out_valid && dif.coin_ack) begin
        if (exp_q.size() == 0) begin
          chk("coin_unexpected", int'(dif.coin_out), 0);
        end else begin
          e = exp_q.pop_front();
          chk("coin_order", 0, int'(e.is_done));
          chk("coin_type", int'(dif.coin_out), e.val);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("done_unexpected", int'(shortfall), -1);
        end else begin
          e = exp_q.pop_front();
          chk("done_order", 1, int'(e.is_done));
          chk("done_shortfall", int'(shortfall), e.val);
        end
      end
    end
  end

  initial begin
    int cnt;
    reset             = 1'b1;
    dif.change_valid  = 1'b0;
    dif.change_amount = '0;
    refill_en         = 1'b0;
    refill_type       = '0;
    refill_count      = '0;
    clear_fault       = 1'b0;
    do_reset();

    chk("rst_ready", int'(dif.change_ready), 1);
    chk("rst_state", int'(state_out), 0);
    chk("rst_valid", int'(dif.coin_out_valid), 0);
    chk("rst_coin", int'(dif.coin_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(shortfall), 0);
    chk("rst_fault", int'(fault), 0);
    check_inv("rst", 20, 20, 20);

    // 18 = 10 + 5 + 1 + 1 + 1
    ack_en = 1;
    push_coin(3); push_coin(2); push_coin(1); push_coin(1); push_coin(1); push_done(0);
    send(18);
    wait_done("amt18");
    check_inv("amt18", 17, 19, 19);

    // Zero amount: SELECT then DONE, no coin offered
    push_done(0);
    send(0);
    chk("zero_state_sel", int'(state_out), 1);
    chk("zero_done_early", int'(done), 0);
    tick();
    chk("zero_done", int'(done), 1);
    chk("zero_state_done", int'(state_out), 3);
    chk("zero_valid", int'(dif.coin_out_valid), 0);
    tick();
    chk("zero_back_idle", int'(state_out), 0);

    // Hopper silent: 15 offer cycles then FAULT
    ack_en = 0;
    send(5);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dif.coin_out_valid) cnt++;
      else if (cnt > 0) break;
    end
    chk("tmo_valid_cycles", cnt, 15);
    chk("tmo_fault", int'(fault), 1);
    chk("tmo_state", int'(state_out), 4);
    chk("tmo_ready", int'(dif.change_ready), 0);
    chk("tmo_inv_5", int'(inv_5), 19);
    dif.change_valid = 1'b1;
    tick(); tick();
    dif.change_valid = 1'b0;
    chk("fault_sticky", int'(state_out), 4);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_state", int'(state_out), 0);
    chk("clr_ready", int'(dif.change_ready), 1);
    chk("clr_fault", int'(fault), 0);

    // Drain the tens, then 20 must come out as four fives
    do_reset();
    check_inv("rst2", 20, 20, 20);
    ack_en = 1;
    for (int i = 0; i < 10; i++) begin
      push_coin(3); push_coin(3); push_done(0);
      send(20);
      wait_done("drain10");
    end
    chk("drain_inv_10", int'(inv_10), 0);
    push_coin(2); push_coin(2); push_coin(2); push_coin(2); push_done(0);
    send(20);
    wait_done("amt20_fives");
    check_inv("amt20_fives", 20, 16, 0);

    // Drain fives and all but one single, then ask for 3
    for (int i = 0; i < 4; i++) begin
      push_coin(2); push_coin(2); push_coin(2); push_coin(2); push_done(0);
      send(20);
      wait_done("drain5");
    end
    for (int i = 0; i < 19; i++) push_coin(1);
    push_done(0);
    send(19);
    wait_done("drain1");
    check_inv("drained", 1, 0, 0);
    push_coin(1); push_done(2);
    send(3);
    wait_done("short");
    chk("short_held", int'(shortfall), 2);
    chk("short_inv_1", int'(inv_1), 0);

    // Refill: saturation, ignored type 00
    refill_en = 1'b1; refill_type = 2'b01; refill_count = 6'd63;
    tick();
    refill_count = 6'd5;
    tick();
    refill_type = 2'b00; refill_count = 6'd9;
    tick();
    refill_type = 2'b10; refill_count = 6'd7;
    tick();
    refill_en = 1'b0;
    check_inv("refill", 63, 7, 0);

    // Ack while IDLE must not touch inventory
    ack_en = 0;
    dif.coin_ack = 1'b1;
    tick(); tick();
    dif.coin_ack = 1'b0;
    chk("idle_ack_state", int'(state_out), 0);
    chk("idle_ack_inv_5", int'(inv_5), 7);

    // Same-cycle ack and refill on fives: 7 - 1 + 3
    push_coin(2); push_done(0);
    send(5);
    wait_valid("same");
    dif.coin_ack = 1'b1;
    refill_en = 1'b1; refill_type = 2'b10; refill_count = 6'd3;
    tick();
    dif.coin_ack = 1'b0;
    refill_en = 1'b0;
    wait_done("same");
    chk("same_inv_5", int'(inv_5), 9);

    // Reset while a coin is on offer
    send(5);
    wait_valid("rstdisp");
    reset = 1'b1;
    #1;
    chk("rstdisp_valid", int'(dif.coin_out_valid), 0);
    chk("rstdisp_state", int'(state_out), 0);
    chk("rstdisp_ready", int'(dif.change_ready), 1);
    check_inv("rstdisp", 20, 20, 20);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rstdisp_idle", int'(state_out), 0);

    tick(); tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

endmodule
